mem_arbiter: RTL and testbench

Arbitrates the single main-memory port between the instruction-cache and data-cache refill/writeback paths. It sits below both caches: Stage 1 fetch misses arrive on the `ic_*` port, and Stage 3 load/store misses and writebacks arrive on the `dc_*` port. Exactly one memory transaction is outstanding at a time. The arbiter sequences each transaction through request, write-data and response phases, and routes read data back to the owning cache.

---
 rtl/mem_arbiter.sv | 249 ++++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Purpose:
//   Shares the single main-memory port between the instruction-cache refill
//   path (ic_*) and the data-cache refill/writeback path (dc_*). Only one
//   memory transaction is outstanding at a time. Each transaction goes
//   through a command phase, an optional write-data phase and, for reads, a
//   response phase whose data is routed back to the cache that owns it.
//
// Configuration:
//   MEM_ARB_RR_EN  defined   -> round-robin on ties. A 1-bit last-owner
//                               register resets to icache, so dcache wins
//                               the first tie.
//                  undefined -> fixed dcache priority on ties.
//
// Ports:
//   clk, reset        clock (posedge) and asynchronous active-high reset
//   ic_req_*          icache read request (valid/addr in, ready out)
//   ic_resp_*         icache read data (valid/data out)
//   dc_req_*          dcache request (valid/rw/addr/data/mask in, ready out)
//   dc_resp_*         dcache read data (valid/data out)
//   mem_req_*         memory command channel (valid/rw/addr out, ready in)
//   mem_data_*        memory write-data channel (valid/data/mask out,
//                     ready in)
//   mem_resp_*        memory read-data return (valid/data in)
//   dbg_state_o       current FSM state: 0=IDLE 1=CMD 2=WDATA 3=RESP
//
// Handshake semantics (all request/command/data channels):
//   A transfer happens on a rising clock edge where valid and ready are both
//   1. A source holds valid and its payload stable until that edge. The
//   arbiter never withdraws mem_req_valid or mem_data_valid before their
//   handshake. mem_resp_valid has no ready: it is a one-cycle pulse and is
//   only accepted in RESP.
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 128
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  ic_req_valid,
    input  logic [ADDR_W-1:0]     ic_req_addr,
    output logic                  ic_req_ready,
    output logic                  ic_resp_valid,
    output logic [DATA_W-1:0]     ic_resp_data,

    input  logic                  dc_req_valid,
    input  logic                  dc_req_rw,
    input  logic [ADDR_W-1:0]     dc_req_addr,
    input  logic [DATA_W-1:0]     dc_req_data,
    input  logic [DATA_W/8-1:0]   dc_req_mask,
    output logic                  dc_req_ready,
    output logic                  dc_resp_valid,
    output logic [DATA_W-1:0]     dc_resp_data,

    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_rw,
    output logic [ADDR_W-1:0]     mem_req_addr,
    output logic                  mem_data_valid,
    input  logic                  mem_data_ready,
    output logic [DATA_W-1:0]     mem_data,
    output logic [DATA_W/8-1:0]   mem_mask,
    input  logic                  mem_resp_valid,
    input  logic [DATA_W-1:0]     mem_resp_data,

    output logic [1:0]            dbg_state_o
);

    localparam int MASK_W = DATA_W / 8;

    // Owner encoding, shared by owner_q and the round-robin last-owner bit.
    localparam logic OWNER_IC = 1'b0;
    localparam logic OWNER_DC = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMD   = 2'd1,
        ST_WDATA = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t              state_q;
    logic                owner_q;
    logic                rw_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic [MASK_W-1:0]   mask_q;
    logic                mem_req_valid_q;
    logic                mem_data_valid_q;

`ifdef MEM_ARB_RR_EN
    logic                last_owner_q;
`endif

    // -----------------------------------------------------------------------
    // Grant selection (combinational, only meaningful in IDLE)
    // -----------------------------------------------------------------------
    logic grant_ic;
    logic grant_dc;

    always_comb begin
        grant_ic = 1'b0;
        grant_dc = 1'b0;
`ifdef MEM_ARB_RR_EN
        if (ic_req_valid && dc_req_valid) begin
            // Tie: whichever port was not granted last time wins.
            if (last_owner_q == OWNER_IC) begin
                grant_dc = 1'b1;
            end else begin
                grant_ic = 1'b1;
            end
        end else begin
            grant_ic = ic_req_valid;
            grant_dc = dc_req_valid;
        end
`else
        grant_dc = dc_req_valid;
        grant_ic = ic_req_valid && !dc_req_valid;
`endif
    end

    logic in_idle;
    assign in_idle = (state_q == ST_IDLE);

    // Readies are forced low while reset is asserted, even though the state
    // is already IDLE, so no handshake can be seen during reset.
    assign ic_req_ready = !reset && in_idle && grant_ic;
    assign dc_req_ready = !reset && in_idle && grant_dc;

    // -----------------------------------------------------------------------
    // Payload captured on the request handshake
    // -----------------------------------------------------------------------
    logic                owner_d;
    logic                rw_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [DATA_W-1:0]   data_d;
    logic [MASK_W-1:0]   mask_d;

    always_comb begin
        owner_d = OWNER_IC;
        rw_d    = 1'b0;          // icache traffic is always a read
        addr_d  = ic_req_addr;
        data_d  = '0;
        mask_d  = '0;
        if (grant_dc) begin
            owner_d = OWNER_DC;
            rw_d    = dc_req_rw;
            addr_d  = dc_req_addr;
            data_d  = dc_req_data;
            mask_d  = dc_req_mask;
        end
    end

    // -----------------------------------------------------------------------
    // Transaction FSM with registered memory-side valids
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            owner_q          <= OWNER_IC;
            rw_q             <= 1'b0;
            addr_q           <= '0;
            data_q           <= '0;
            mask_q           <= '0;
            mem_req_valid_q  <= 1'b0;
            mem_data_valid_q <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_owner_q     <= OWNER_IC;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_ic || grant_dc) begin
                        owner_q         <= owner_d;
                        rw_q            <= rw_d;
                        addr_q          <= addr_d;
                        data_q          <= data_d;
                        mask_q          <= mask_d;
                        mem_req_valid_q <= 1'b1;
                        state_q         <= ST_CMD;
`ifdef MEM_ARB_RR_EN
                        last_owner_q    <= owner_d;
`endif
                    end
                end

                // A response arriving together with the command handshake
                // belongs to nobody: only the command handshake is acted on.
                ST_CMD: begin
                    if (mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        if (rw_q) begin
                            mem_data_valid_q <= 1'b1;
                            state_q          <= ST_WDATA;
                        end else begin
                            state_q          <= ST_RESP;
                        end
                    end
                end

                // Writes complete silently: no requester response.
                ST_WDATA: begin
                    if (mem_data_ready) begin
                        mem_data_valid_q <= 1'b0;
                        state_q          <= ST_IDLE;
                    end
                end

                ST_RESP: begin
                    if (mem_resp_valid) begin
                        state_q <= ST_IDLE;
                    end
                end

                default: begin
                    mem_req_valid_q  <= 1'b0;
                    mem_data_valid_q <= 1'b0;
                    state_q          <= ST_IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign mem_req_valid  = mem_req_valid_q;
    assign mem_req_rw     = rw_q;
    assign mem_req_addr   = addr_q;
    assign mem_data_valid = mem_data_valid_q;
    assign mem_data       = data_q;
    assign mem_mask       = mask_q;

    // Read data is passed straight through in the cycle it arrives; the
    // valid is steered to the owner only, and only while in RESP.
    logic resp_fire;
    assign resp_fire = !reset && (state_q == ST_RESP) && mem_resp_valid;

    assign ic_resp_valid = resp_fire && (owner_q == OWNER_IC);
    assign dc_resp_valid = resp_fire && (owner_q == OWNER_DC);
    assign ic_resp_data  = mem_resp_data;
    assign dc_resp_data  = mem_resp_data;

    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Self-checking bench for mem_arbiter. A transaction-level model tracks the
// single outstanding transaction (busy / command accepted / owner / payload)
// and a compare process checks every DUT output against it on each falling
// edge. Directed sequences cover the icache read, dcache write, tie
// arbitration, reset mid-read and stray responses, with hand-computed
// literal expectations on top.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 128;
  localparam int MASK_W = DATA_W / 8;

  localparam logic [DATA_W-1:0] RD_DATA_1 = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;
  localparam logic [DATA_W-1:0] WR_DATA_1 = 128'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0;
  localparam logic [DATA_W-1:0] RD_DATA_2 = 128'hCAFE_F00D_1234_5678_9ABC_DEF0_1357_2468;
  localparam logic [DATA_W-1:0] RD_DATA_3 = 128'h5555_AAAA_3333_CCCC_0F0F_F0F0_00FF_FF00;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic                ic_req_valid;
  logic [ADDR_W-1:0]   ic_req_addr;
  logic                ic_req_ready;
  logic                ic_resp_valid;
  logic [DATA_W-1:0]   ic_resp_data;
  logic                dc_req_valid;
  logic                dc_req_rw;
  logic [ADDR_W-1:0]   dc_req_addr;
  logic [DATA_W-1:0]   dc_req_data;
  logic [MASK_W-1:0]   dc_req_mask;
  logic                dc_req_ready;
  logic                dc_resp_valid;
  logic [DATA_W-1:0]   dc_resp_data;
  logic                mem_req_valid;
  logic                mem_req_ready;
  logic                mem_req_rw;
  logic [ADDR_W-1:0]   mem_req_addr;
  logic                mem_data_valid;
  logic                mem_data_ready;
  logic [DATA_W-1:0]   mem_data;
  logic [MASK_W-1:0]   mem_mask;
  logic                mem_resp_valid;
  logic [DATA_W-1:0]   mem_resp_data;
  logic [1:0]          dbg_state_o;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .ic_req_valid   (ic_req_valid),
    .ic_req_addr    (ic_req_addr),
    .ic_req_ready   (ic_req_ready),
    .ic_resp_valid  (ic_resp_valid),
    .ic_resp_data   (ic_resp_data),
    .dc_req_valid   (dc_req_valid),
    .dc_req_rw      (dc_req_rw),
    .dc_req_addr    (dc_req_addr),
    .dc_req_data    (dc_req_data),
    .dc_req_mask    (dc_req_mask),
    .dc_req_ready   (dc_req_ready),
    .dc_resp_valid  (dc_resp_valid),
    .dc_resp_data   (dc_resp_data),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_rw     (mem_req_rw),
    .mem_req_addr   (mem_req_addr),
    .mem_data_valid (mem_data_valid),
    .mem_data_ready (mem_data_ready),
    .mem_data       (mem_data),
    .mem_mask       (mem_mask),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .dbg_state_o    (dbg_state_o)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- transaction model ----------------
  // One outstanding transaction: busy, whether its command has been
  // accepted, owner (1 = dcache) and the captured payload.
  bit                m_busy;
  bit                m_cmd_done;
  bit                m_owner;
  bit                m_rw;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  logic [MASK_W-1:0] m_mask;
  bit                m_last;   // last granted port, 0 = icache

  // Which port wins given the current request inputs: {dc, ic}.
  function automatic logic [1:0] model_grant();
    if (!dc_req_valid) return {1'b0, ic_req_valid};
    if (!ic_req_valid) return 2'b10;
`ifdef MEM_ARB_RR_EN
    return (m_last == 1'b0) ? 2'b10 : 2'b01;
`else
    return 2'b10;
`endif
  endfunction

  initial begin
    m_busy = 0; m_cmd_done = 0; m_owner = 0; m_rw = 0;
    m_addr = '0; m_data = '0; m_mask = '0; m_last = 0;
  end

  always @(posedge clk) begin
    if (reset) begin
      m_busy     <= 1'b0;
      m_cmd_done <= 1'b0;
      m_last     <= 1'b0;
    end else if (!m_busy) begin
      if (model_grant() != 2'b00) begin
        m_busy     <= 1'b1;
        m_cmd_done <= 1'b0;
        m_owner    <= model_grant() == 2'b10;
        m_rw       <= (model_grant() == 2'b10) && dc_req_rw;
        m_addr     <= (model_grant() == 2'b10) ? dc_req_addr : ic_req_addr;
        m_data     <= dc_req_data;
        m_mask     <= dc_req_mask;
        m_last     <= model_grant() == 2'b10;
      end
    end else if (!m_cmd_done) begin
      if (mem_req_ready) m_cmd_done <= 1'b1;
    end else if (m_rw) begin
      if (mem_data_ready) m_busy <= 1'b0;
    end else if (mem_resp_valid) begin
      m_busy <= 1'b0;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [1:0] g;
    logic       e_idle, e_cmd, e_wd, e_resp;
    logic [1:0] e_state;
    g      = model_grant();
    e_idle = !reset && !m_busy;
    e_cmd  = !reset && m_busy && !m_cmd_done;
    e_wd   = !reset && m_busy && m_cmd_done && m_rw;
    e_resp = !reset && m_busy && m_cmd_done && !m_rw && mem_resp_valid;
    if (reset || !m_busy) e_state = 2'd0;
    else if (!m_cmd_done) e_state = 2'd1;
    else if (m_rw)        e_state = 2'd2;
    else                  e_state = 2'd3;

    check("ic_req_ready",   ic_req_ready,   e_idle && g[0]);
    check("dc_req_ready",   dc_req_ready,   e_idle && g[1]);
    check("mem_req_valid",  mem_req_valid,  e_cmd);
    check("mem_data_valid", mem_data_valid, e_wd);
    check("ic_resp_valid",  ic_resp_valid,  e_resp && !m_owner);
    check("dc_resp_valid",  dc_resp_valid,  e_resp && m_owner);
    check("state",          dbg_state_o,    e_state);
    if (e_cmd) begin
      check("mem_req_rw",   mem_req_rw,   m_rw);
      check("mem_req_addr", mem_req_addr, m_addr);
    end
    if (e_wd) begin
      check("mem_data", mem_data, m_data);
      check("mem_mask", mem_mask, m_mask);
    end
    if (e_resp && !m_owner) check("ic_resp_data", ic_resp_data, mem_resp_data);
    if (e_resp && m_owner)  check("dc_resp_data", dc_resp_data, mem_resp_data);
  end

  // ---------------- observation counters (DUT side) ----------------
  int                ic_resp_cnt = 0;
  int                dc_resp_cnt = 0;
  int                wdata_cnt   = 0;
  int                rw1_cnt     = 0;
  logic [DATA_W-1:0] last_ic_data = '0;
  logic [DATA_W-1:0] last_dc_data = '0;
  logic [DATA_W-1:0] exp_q[$];     // expected response data, in order
  logic              grant_log[$]; // 1 = dcache granted, 0 = icache

  always @(negedge clk) begin
    if (ic_resp_valid) begin ic_resp_cnt++; last_ic_data = ic_resp_data; end
    if (dc_resp_valid) begin dc_resp_cnt++; last_dc_data = dc_resp_data; end
    if (mem_data_valid) wdata_cnt++;
    if (mem_req_valid && mem_req_rw) rw1_cnt++;
    if (dc_req_ready) grant_log.push_back(1'b1);
    else if (ic_req_ready) grant_log.push_back(1'b0);
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_inputs();
    ic_req_valid   = 0; ic_req_addr = '0;
    dc_req_valid   = 0; dc_req_rw   = 0; dc_req_addr = '0;
    dc_req_data    = '0; dc_req_mask = '0;
    mem_req_ready  = 0; mem_data_ready = 0;
    mem_resp_valid = 0; mem_resp_data  = '0;
  endtask

  task automatic do_reset();
    reset = 1;
    clear_inputs();
    step(2);
    reset = 0;
    step(1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // ---------------- directed sequences ----------------
  initial begin
    int s_ic, s_dc, s_wd, s_rw, g0, n_grants;
    logic [3:0] exp_pat;

    clear_inputs();
    // Requests held during reset must not be granted.
    reset = 1;
    ic_req_valid = 1; dc_req_valid = 1;
    step(3);
    check("rst_ic_ready", ic_req_ready, 1'b0);
    check("rst_dc_ready", dc_req_ready, 1'b0);
    check("rst_mem_valid", mem_req_valid, 1'b0);
    check("rst_state", dbg_state_o, 2'd0);
    ic_req_valid = 0; dc_req_valid = 0;
    reset = 0;
    step(1);

    // ---- icache read: accepted after 2 cmd cycles, data 3 cycles later ----
    s_ic = ic_resp_cnt; s_dc = dc_resp_cnt;
    exp_q.push_back(RD_DATA_1);
    ic_req_valid = 1; ic_req_addr = 32'h0000_1000;
    step(1);
    ic_req_valid = 0;
    check("ic_rd_in_cmd", dbg_state_o, 2'd1);
    check("ic_rd_addr", mem_req_addr, 32'h0000_1000);
    step(1);
    mem_req_ready = 1;
    step(1);
    mem_req_ready = 0;
    step(2);
    mem_resp_valid = 1; mem_resp_data = RD_DATA_1;
    step(1);
    mem_resp_valid = 0; mem_resp_data = '0;
    step(2);
    check("ic_rd_pulses", ic_resp_cnt - s_ic, 1);
    check("ic_rd_data", last_ic_data, exp_q.pop_front());
    check("ic_rd_no_dc", dc_resp_cnt - s_dc, 0);

    // ---- dcache write: data phase held for 4 cycles ----
    s_dc = dc_resp_cnt; s_wd = wdata_cnt; s_rw = rw1_cnt;
    dc_req_valid = 1; dc_req_rw = 1; dc_req_addr = 32'h0000_2040;
    dc_req_mask = 16'hFFFF; dc_req_data = WR_DATA_1;
    step(1);
    dc_req_valid = 0; dc_req_rw = 0;
    mem_req_ready = 1;
    step(1);
    mem_req_ready = 0;
    check("dc_wr_in_wdata", dbg_state_o, 2'd2);
    check("dc_wr_data", mem_data, WR_DATA_1);
    step(3);
    mem_data_ready = 1;
    step(1);
    mem_data_ready = 0;
    check("dc_wr_back_idle", dbg_state_o, 2'd0);
    step(2);
    check("dc_wr_wdata_cycles", wdata_cnt - s_wd, 4);
    check("dc_wr_rw_cycles", rw1_cnt - s_rw, 1);
    check("dc_wr_no_resp", dc_resp_cnt - s_dc, 0);

    // ---- tie: both request continuously, memory always ready ----
    do_reset();
    s_ic = ic_resp_cnt; s_dc = dc_resp_cnt;
    g0 = grant_log.size();
    ic_req_valid = 1; ic_req_addr = 32'h0000_3000;
    dc_req_valid = 1; dc_req_rw = 0; dc_req_addr = 32'h0000_4000;
    mem_req_ready = 1; mem_resp_valid = 1;
    for (int i = 0; i < 12; i++) begin
      mem_resp_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      step(1);
    end
    ic_req_valid = 0; dc_req_valid = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = '0;
    step(2);
    n_grants = grant_log.size() - g0;
    check("tie_grants", n_grants, 4);
`ifdef MEM_ARB_RR_EN
    exp_pat = 4'b0101;   // dc, ic, dc, ic
    check("tie_ic_resps", ic_resp_cnt - s_ic, 2);
    check("tie_dc_resps", dc_resp_cnt - s_dc, 2);
`else
    exp_pat = 4'b1111;   // dcache every time
    check("tie_ic_resps", ic_resp_cnt - s_ic, 0);
    check("tie_dc_resps", dc_resp_cnt - s_dc, 4);
`endif
    for (int k = 0; k < 4; k++) begin
      if (k < n_grants) check($sformatf("tie_grant%0d", k), grant_log[g0 + k], exp_pat[k]);
    end

    // ---- reset while waiting for read data ----
    s_ic = ic_resp_cnt; s_dc = dc_resp_cnt;
    ic_req_valid = 1; ic_req_addr = 32'h0000_5000;
    step(1);
    ic_req_valid = 0;
    mem_req_ready = 1;
    step(1);
    mem_req_ready = 0;
    check("rst_resp_in_resp", dbg_state_o, 2'd3);
    step(1);
    reset = 1;
    step(2);
    reset = 0;
    step(1);
    mem_resp_valid = 1; mem_resp_data = RD_DATA_3;
    step(1);
    mem_resp_valid = 0; mem_resp_data = '0;
    check("rst_resp_no_ic", ic_resp_cnt - s_ic, 0);
    check("rst_resp_no_dc", dc_resp_cnt - s_dc, 0);
    check("rst_resp_idle", dbg_state_o, 2'd0);
    // next request handled normally
    exp_q.push_back(RD_DATA_2);
    dc_req_valid = 1; dc_req_rw = 0; dc_req_addr = 32'h0000_6000;
    step(1);
    dc_req_valid = 0;
    mem_req_ready = 1;
    step(1);
    mem_req_ready = 0;
    mem_resp_valid = 1; mem_resp_data = RD_DATA_2;
    step(1);
    mem_resp_valid = 0; mem_resp_data = '0;
    step(1);
    check("post_rst_dc_resps", dc_resp_cnt - s_dc, 1);
    check("post_rst_dc_data", last_dc_data, exp_q.pop_front());

    // ---- stray responses in IDLE and CMD ----
    s_ic = ic_resp_cnt; s_dc = dc_resp_cnt;
    mem_resp_valid = 1; mem_resp_data = RD_DATA_3;
    step(1);
    mem_resp_valid = 0;
    check("stray_idle_state", dbg_state_o, 2'd0);
    ic_req_valid = 1; ic_req_addr = 32'h0000_7000;
    step(1);
    ic_req_valid = 0;
    mem_resp_valid = 1;
    step(1);
    mem_resp_valid = 0;
    check("stray_cmd_state", dbg_state_o, 2'd1);
    check("stray_cmd_valid", mem_req_valid, 1'b1);
    check("stray_no_resp", (ic_resp_cnt - s_ic) + (dc_resp_cnt - s_dc), 0);
    mem_req_ready = 1;
    step(1);
    mem_req_ready = 0;
    mem_resp_valid = 1; mem_resp_data = RD_DATA_1;
    step(1);
    mem_resp_valid = 0; mem_resp_data = '0;
    step(1);
    check("stray_then_ic_resp", ic_resp_cnt - s_ic, 1);
    check("stray_then_ic_data", last_ic_data, RD_DATA_1);
    check("stray_then_no_dc", dc_resp_cnt - s_dc, 0);

    step(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
